ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of keyboard_ps2, in the 50 MHz domain.
- Consumes the raw received-byte stream and decodes PS/2 Set-2 multi-byte sequences (E0 extended prefix, F0 break prefix, 8-byte E1 Pause) into single key events.
- Buffers events in a small FIFO behind a valid/ready handshake and tracks Shift/Ctrl/Alt levels.

Parameters:
- FIFO_DEPTH, 4, number of event entries; power of two, 2..16.
- TIMEOUT_CYCLES, 1_000_000, idle cycles (20 ms at 50 MHz) after which a partial sequence is abandoned.

Ports:
- clock_50  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  byte received from keyboard_ps2.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
- ev_code  output  8  scan code of the head event.
- ev_ext  output  1  head event was E0-prefixed (Pause also sets this).
- ev_break  output  1  head event is a release (F0-prefixed).
- ev_valid  output  1  FIFO not empty.
- ev_ready  input  1  consumer accepts the head event when ev_valid && ev_ready.
- mod_shift  output  1  left or right Shift held.
- mod_ctrl  output  1  left or right Ctrl held.
- mod_alt  output  1  left or right Alt held.
- bat_ok  output  1  one-cycle pulse on a BAT-pass byte (AA) received in IDLE.
- ev_drop  output  1  one-cycle pulse when a complete event is discarded because the FIFO is full.

Behaviour:
- Reset (synchronous, active-high), all of these in the same clock edge:
  - FSM goes to IDLE; ext/brk flags cleared; timeout counter cleared.
  - FIFO emptied, so ev_valid=0 and ev_code/ev_ext/ev_break read 0.
  - mod_shift, mod_ctrl, mod_alt, bat_ok and ev_drop all 0.
  - Reset asserted mid-sequence discards the partial sequence.
- FSM states:
  - IDLE: E0 sets ext and goes to PREFIX. F0 sets brk and goes to PREFIX. E1 goes to PAUSE with index 1. AA pulses bat_ok. 00, FF, FA, FE and EE are discarded. Any other byte completes an event with ext=0, brk=0.
  - PREFIX: F0 sets brk and stays. E0 sets ext and stays. E1 is discarded and the FSM returns to IDLE with flags cleared. Any other byte completes an event with the accumulated flags.
  - PAUSE: each byte is compared with the expected sequence E1 14 77 E1 F0 14 F0 77 at index 1..7.
    - Match: increment the index; after index 7 matches, complete one event code=77, ext=1, brk=0.
    - Mismatch: return to IDLE and discard that byte; it is not reinterpreted.
- Event completion:
  - The decoded word {ext, brk, code} is pushed into the FIFO on the clock edge that samples the final rx_valid.
  - ev_valid/ev_* therefore become visible the next cycle (latency 1 when the FIFO was empty).
  - The FSM returns to IDLE and clears ext/brk on that same edge.
- Modifiers update on the same edge as the push. Make sets the bit and break clears it:
  - Shift: code 12 or 59 with ext=0.
  - Ctrl: code 14 with ext=0 or ext=1.
  - Alt: code 11 with ext=0 or ext=1.
  - Each mod_* output is the OR of its left and right held bits.
  - E0 12 (fake shift) and E0 59 do not affect modifiers but are still pushed as events.
  - Modifier state updates even when the event is dropped for FIFO-full.
- Timeout: the counter runs while the FSM is not in IDLE and clears on every rx_valid. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, flags clear, and nothing is pushed.
- FIFO behaviour:
  - Pop when ev_valid && ev_ready.
  - Push while full and no pop in the same cycle: the event is discarded and ev_drop pulses 1 cycle later.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle while empty: the push succeeds and no pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head outputs are stable while ev_valid=1 and ev_ready=0.
- rx_valid arrives at most once per cycle; back-to-back strobes in consecutive cycles must be handled.

Test Plan:
1. Bytes 1C, then F0 1C, ev_ready=1 → events {ext0,brk0,1C} then {ext0,brk1,1C}, each ev_valid one cycle after its last byte.
2. Bytes E0 F0 75 → single event {ext1,brk1,75}; bytes E0 14 → mod_ctrl=1; E0 F0 14 → mod_ctrl=0.
3. Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {ext1,brk0,77}. Repeat with 5th byte 12 → no event, FSM in IDLE; the next byte 1C yields {0,0,1C}.
4. ev_ready=0 and six make codes 15,1D,24,2D,2C,35 with FIFO_DEPTH=4 → first four retained in order, ev_drop pulses twice. Raise ev_ready → four pops, then ev_valid=0.
5. Byte E0, then 1_000_000 idle cycles, then 1C → event {ext0,brk0,1C}; AA in IDLE → bat_ok pulse, no event.
6. Byte F0, reset for 1 cycle, then 1C → {0,0,1C}; 12 then reset → mod_shift=0, ev_valid=0 on the cycle after reset.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0 prefixes and the 8-byte E1 Pause
// sequence into single key events, queues them in a small FIFO behind a
// valid/ready handshake, and tracks Shift/Ctrl/Alt held levels.
//
// Ports:
//   clock_50   in   50 MHz system clock
//   reset      in   synchronous active-high reset
//   rx_data    in   [7:0] byte from keyboard_ps2
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   ev_code    out  [7:0] scan code of head event (0 when empty)
//   ev_ext     out  head event was E0-prefixed (also set for Pause)
//   ev_break   out  head event is a release
//   ev_valid   out  FIFO not empty
//   ev_ready   in   consumer takes head when ev_valid && ev_ready
//   mod_shift  out  either Shift held
//   mod_ctrl   out  either Ctrl held
//   mod_alt    out  either Alt held
//   bat_ok     out  one-cycle pulse after AA received in IDLE
//   ev_drop    out  one-cycle pulse after an event is lost to a full FIFO
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       bat_ok,
    output logic       ev_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        PAUSE
    } state_t;

    state_t        state, state_n;
    logic          ext, ext_n;
    logic          brk, brk_n;
    logic [2:0]    pidx, pidx_n;
    logic [TW-1:0] tcnt;

    logic          push;
    logic [7:0]    push_code;
    logic          push_ext;
    logic          push_brk;
    logic          bat_hit;
    logic [7:0]    pause_exp;

    // Held bits for left/right modifier keys
    logic lsh, rsh, lct, rct, lal, ral;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, accept;
    logic [10:0]   head;

    // Expected Pause byte at index 1..7 (index 0 is the E1 seen in IDLE)
    always_comb begin
        case (pidx)
            3'd1:    pause_exp = 8'h14;
            3'd2:    pause_exp = 8'h77;
            3'd3:    pause_exp = 8'hE1;
            3'd4:    pause_exp = 8'hF0;
            3'd5:    pause_exp = 8'h14;
            3'd6:    pause_exp = 8'hF0;
            3'd7:    pause_exp = 8'h77;
            default: pause_exp = 8'hE1;
        endcase
    end

    always_comb begin
        state_n   = state;
        ext_n     = ext;
        brk_n     = brk;
        pidx_n    = pidx;
        push      = 1'b0;
        push_code = rx_data;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        bat_hit   = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    case (rx_data)
                        8'hE0: begin
                            ext_n   = 1'b1;
                            state_n = PREFIX;
                        end
                        8'hF0: begin
                            brk_n   = 1'b1;
                            state_n = PREFIX;
                        end
                        8'hE1: begin
                            pidx_n  = 3'd1;
                            state_n = PAUSE;
                        end
                        8'hAA: bat_hit = 1'b1;
                        8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE: ;
                        default: push = 1'b1;
                    endcase
                end
                PREFIX: begin
                    case (rx_data)
                        8'hF0: brk_n = 1'b1;
                        8'hE0: ext_n = 1'b1;
                        8'hE1: begin
                            state_n = IDLE;
                            ext_n   = 1'b0;
                            brk_n   = 1'b0;
                        end
                        default: begin
                            push     = 1'b1;
                            push_ext = ext;
                            push_brk = brk;
                            state_n  = IDLE;
                            ext_n    = 1'b0;
                            brk_n    = 1'b0;
                        end
                    endcase
                end
                PAUSE: begin
                    if (rx_data == pause_exp) begin
                        if (pidx == 3'd7) begin
                            push      = 1'b1;
                            push_code = 8'h77;
                            push_ext  = 1'b1;
                            state_n   = IDLE;
                        end else begin
                            pidx_n = pidx + 3'd1;
                        end
                    end else begin
                        // Mismatched byte is swallowed, not re-decoded
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    ext_n   = 1'b0;
                    brk_n   = 1'b0;
                end
            endcase
        end else if (state != IDLE && tcnt == TO_LAST) begin
            state_n = IDLE;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state <= IDLE;
            ext   <= 1'b0;
            brk   <= 1'b0;
            pidx  <= 3'd0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            ext   <= ext_n;
            brk   <= brk_n;
            pidx  <= pidx_n;
            if (rx_valid || state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt != TO_LAST) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Modifiers follow every completed event, even one the FIFO drops
    always_ff @(posedge clock_50) begin
        if (reset) begin
            lsh <= 1'b0;
            rsh <= 1'b0;
            lct <= 1'b0;
            rct <= 1'b0;
            lal <= 1'b0;
            ral <= 1'b0;
        end else if (push) begin
            if (!push_ext && push_code == 8'h12) lsh <= !push_brk;
            if (!push_ext && push_code == 8'h59) rsh <= !push_brk;
            if (!push_ext && push_code == 8'h14) lct <= !push_brk;
            if (push_ext && push_code == 8'h14)  rct <= !push_brk;
            if (!push_ext && push_code == 8'h11) lal <= !push_brk;
            if (push_ext && push_code == 8'h11)  ral <= !push_brk;
        end
    end

    assign mod_shift = lsh | rsh;
    assign mod_ctrl  = lct | rct;
    assign mod_alt   = lal | ral;

    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    assign full     = (count == DEPTH_C);
    assign accept   = push && (!full || pop);

    always_ff @(posedge clock_50) begin
        if (accept) begin
            mem[wr_ptr] <= {push_ext, push_brk, push_code};
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            bat_ok  <= 1'b0;
            ev_drop <= 1'b0;
        end else begin
            bat_ok  <= bat_hit;
            ev_drop <= push && !accept;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head reads as zero while empty so stale entries never leak out
    assign head     = ev_valid ? mem[rd_ptr] : '0;
    assign ev_code  = head[7:0];
    assign ev_break = head[8];
    assign ev_ext   = head[9];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: byte-stream reference model
// feeds an expected-event queue that an independent monitor drains.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic       clock_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext, ev_break, ev_valid;
    logic       mod_shift, mod_ctrl, mod_alt, bat_ok, ev_drop;

    always #10 clock_50 = ~clock_50;

    ps2_scancode_decoder #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_break (ev_break),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .mod_shift(mod_shift),
        .mod_ctrl (mod_ctrl),
        .mod_alt  (mod_alt),
        .bat_ok   (bat_ok),
        .ev_drop  (ev_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit rand_rdy = 1'b0;

    // Reference model state
    logic [7:0]  pend[$];
    logic [10:0] exp_q[$];
    int          occ = 0;
    int          gap = 0;
    bit          lsh, rsh, lct, rct, lal, ral;
    bit          bat_exp  = 1'b0;
    bit          drop_exp = 1'b0;
    bit          m_pop, m_has;
    logic [10:0] m_w;
    logic [7:0]  pseq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                              8'hF0, 8'h14, 8'hF0, 8'h77};

    int pops_seen = 0;
    int drop_seen = 0;
    int bat_seen  = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Decode the pending byte list as a whole sequence, not as a state machine
    task automatic decode(input logic [7:0] b, output bit has,
                          output logic [10:0] w);
        bit e, k;
        has = 1'b0;
        w   = '0;
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (b != pseq[pend.size() - 1]) begin
                pend.delete();
            end else if (pend.size() == 8) begin
                has = 1'b1;
                w   = {1'b1, 1'b0, 8'h77};
                pend.delete();
            end
        end else if (pend.size() == 1 && b == 8'hAA) begin
            bat_exp = 1'b1;
            pend.delete();
        end else if (pend.size() == 1 &&
                     (b == 8'h00 || b == 8'hFF || b == 8'hFA ||
                      b == 8'hFE || b == 8'hEE)) begin
            pend.delete();
        end else if (b == 8'hE0 || b == 8'hF0) begin
            // still collecting prefixes
        end else if (b == 8'hE1) begin
            pend.delete();
        end else begin
            e = 1'b0;
            k = 1'b0;
            foreach (pend[i]) begin
                if (pend[i] == 8'hE0) e = 1'b1;
                if (pend[i] == 8'hF0) k = 1'b1;
            end
            has = 1'b1;
            w   = {e, k, b};
            pend.delete();
        end
    endtask

    task automatic upd_mods(input logic [10:0] w);
        bit e, mk;
        e  = w[9];
        mk = !w[8];
        if (!e && w[7:0] == 8'h12) lsh = mk;
        if (!e && w[7:0] == 8'h59) rsh = mk;
        if (!e && w[7:0] == 8'h14) lct = mk;
        if (e && w[7:0] == 8'h14)  rct = mk;
        if (!e && w[7:0] == 8'h11) lal = mk;
        if (e && w[7:0] == 8'h11)  ral = mk;
    endtask

    always @(posedge clock_50) begin
        bat_exp  = 1'b0;
        drop_exp = 1'b0;
        if (reset) begin
            pend.delete();
            exp_q.delete();
            occ = 0;
            gap = 0;
            {lsh, rsh, lct, rct, lal, ral} = '0;
        end else begin
            m_pop = (occ > 0) && ev_ready;
            m_has = 1'b0;
            if (rx_valid) begin
                gap = 0;
                decode(rx_data, m_has, m_w);
            end else if (pend.size() > 0) begin
                gap++;
                if (gap >= TMO) pend.delete();
            end
            if (m_has) begin
                upd_mods(m_w);
                if (occ < DEPTH || m_pop) begin
                    exp_q.push_back(m_w);
                    occ++;
                end else begin
                    drop_exp = 1'b1;
                end
            end
            if (m_pop) occ--;
        end
    end

    always @(negedge clock_50) begin
        if (chk_en) begin
            check("ev_valid", int'(ev_valid), int'(occ > 0));
            if (ev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %0h required none",
                             {ev_ext, ev_break, ev_code});
                end else begin
                    check("event", int'({ev_ext, ev_break, ev_code}),
                          int'(exp_q[0]));
                    if (ev_ready) begin
                        void'(exp_q.pop_front());
                        pops_seen++;
                    end
                end
            end else begin
                check("empty_head", int'({ev_ext, ev_break, ev_code}), 0);
            end
            check("mod_shift", int'(mod_shift), int'(lsh | rsh));
            check("mod_ctrl", int'(mod_ctrl), int'(lct | rct));
            check("mod_alt", int'(mod_alt), int'(lal | ral));
            check("bat_ok", int'(bat_ok), int'(bat_exp));
            check("ev_drop", int'(ev_drop), int'(drop_exp));
            if (ev_drop) drop_seen++;
            if (bat_ok) bat_seen++;
        end
    end

    initial begin
        forever begin
            @(posedge clock_50);
            #1;
            if (rand_rdy) ev_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int g);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock_50);
        #1;
        rx_valid = 1'b0;
        idle(g);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock_50);
        #1;
        reset = 1'b0;
    endtask

    logic [7:0] tbl [16] = '{8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h12, 8'h59,
                             8'h14, 8'h11, 8'h1C, 8'h75, 8'hAA, 8'h00,
                             8'hFA, 8'hE1, 8'h77, 8'h2D};
    logic [7:0] mk6 [6]  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

    initial begin
        int p0, d0, b0;
        logic [7:0] b;
        @(posedge clock_50);
        #1;
        chk_en = 1'b1;
        idle(2);
        reset = 1'b0;

        ev_ready = 1'b1;
        send(8'h1C, 0);
        send(8'hF0, 0);
        send(8'h1C, 3);

        send(8'hE0, 0);
        send(8'hF0, 0);
        send(8'h75, 2);
        send(8'hE0, 1);
        send(8'h14, 2);
        send(8'hE0, 0);
        send(8'hF0, 0);
        send(8'h14, 2);
        send(8'hE0, 0);
        send(8'h12, 2);

        p0 = pops_seen;
        foreach (pseq[i]) send(pseq[i], 0);
        idle(3);
        check("pause_count", pops_seen - p0, 1);
        p0 = pops_seen;
        for (int i = 0; i < 4; i++) send(pseq[i], 0);
        send(8'h12, 1);
        send(8'h1C, 3);
        check("pause_abort", pops_seen - p0, 1);

        ev_ready = 1'b0;
        d0 = drop_seen;
        foreach (mk6[i]) send(mk6[i], 0);
        idle(3);
        check("drop_count", drop_seen - d0, 2);
        p0 = pops_seen;
        ev_ready = 1'b1;
        idle(6);
        check("drain4", pops_seen - p0, 4);

        send(8'hE0, TMO + 10);
        p0 = pops_seen;
        send(8'h1C, 3);
        check("timeout_evt", pops_seen - p0, 1);
        b0 = bat_seen;
        send(8'hAA, 3);
        check("bat_count", bat_seen - b0, 1);

        send(8'hF0, 0);
        pulse_reset();
        send(8'h1C, 3);
        send(8'h12, 1);
        pulse_reset();
        idle(2);

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            if ($urandom_range(0, 9) == 0) begin
                for (int j = 0; j < 8; j++) begin
                    b = pseq[j];
                    if ($urandom_range(0, 7) == 0) b = tbl[$urandom_range(0, 15)];
                    send(b, $urandom_range(0, 1));
                end
            end else begin
                send(tbl[$urandom_range(0, 15)], $urandom_range(0, 2));
            end
            if ($urandom_range(0, 49) == 0) idle(TMO + 3);
        end

        rand_rdy = 1'b0;
        ev_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) idle(1);
        idle(2);
        check("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
